// File: rtl/vliw_pkg.sv
// Shared constants for the two-slot VLIW execute block: data width, opcode map and
// the bit positions of the slot opcode fields inside the instruction word.
package vliw_pkg;

    localparam int WIDTH = 8;
    localparam int OPW   = 8;

    localparam int SLOT1_MSB = 31;
    localparam int SLOT1_LSB = 24;
    localparam int SLOT2_MSB = 23;
    localparam int SLOT2_LSB = 16;

    localparam logic [OPW-1:0] OP_ADD   = 8'h00;
    localparam logic [OPW-1:0] OP_SUB   = 8'h01;
    localparam logic [OPW-1:0] OP_AND   = 8'h02;
    localparam logic [OPW-1:0] OP_OR    = 8'h03;
    localparam logic [OPW-1:0] OP_XOR   = 8'h04;
    localparam logic [OPW-1:0] OP_NOT   = 8'h05;
    localparam logic [OPW-1:0] OP_SHL   = 8'h06;
    localparam logic [OPW-1:0] OP_SHR   = 8'h07;
    localparam logic [OPW-1:0] OP_MUL   = 8'h08;
    localparam logic [OPW-1:0] OP_PASSA = 8'h09;
    localparam logic [OPW-1:0] OP_PASSB = 8'h0A;
    localparam logic [OPW-1:0] OP_INC   = 8'h0B;
    localparam logic [OPW-1:0] OP_DEC   = 8'h0C;

endpackage

// File: rtl/vliw_alu.sv
// Combinational single-slot ALU; arithmetic wraps modulo 2^WIDTH and unknown
// opcodes yield zero.
module vliw_alu
    import vliw_pkg::*;
#(
    parameter int WIDTH = vliw_pkg::WIDTH,
    parameter int OPW   = vliw_pkg::OPW
) (
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (opcode)
            OP_ADD:   y = a + b;
            OP_SUB:   y = a - b;
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOT:   y = ~a;
            // Only the low three bits of B form the shift amount.
            OP_SHL:   y = a << b[2:0];
            OP_SHR:   y = a >> b[2:0];
            OP_MUL:   y = a * b;
            OP_PASSA: y = a;
            OP_PASSB: y = b;
            OP_INC:   y = a + WIDTH'(1);
            OP_DEC:   y = a - WIDTH'(1);
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/vliw_processor.sv
// Two-slot VLIW execute stage: both slots share one operand pair and each result
// is registered, giving one cycle of latency.
module vliw_processor
    import vliw_pkg::*;
#(
    parameter int WIDTH = vliw_pkg::WIDTH,
    parameter int OPW   = vliw_pkg::OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic [WIDTH-1:0] result1,
    output logic [WIDTH-1:0] result2
);

    logic [OPW-1:0]   op1;
    logic [OPW-1:0]   op2;
    logic [WIDTH-1:0] alu1_y;
    logic [WIDTH-1:0] alu2_y;
    logic             unused_reserved;

    assign op1 = instruction[SLOT1_MSB:SLOT1_LSB];
    assign op2 = instruction[SLOT2_MSB:SLOT2_LSB];

    // Reserved field is intentionally ignored.
    assign unused_reserved = ^instruction[15:0];

    vliw_alu #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu1 (
        .opcode (op1),
        .a      (operand1),
        .b      (operand2),
        .y      (alu1_y)
    );

    vliw_alu #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu2 (
        .opcode (op2),
        .a      (operand1),
        .b      (operand2),
        .y      (alu2_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result1 <= '0;
            result2 <= '0;
        end else begin
            result1 <= alu1_y;
            result2 <= alu2_y;
        end
    end

endmodule

// File: tb/tb_vliw_processor.sv
// Directed, table-driven bench for vliw_processor with hand-computed expectations.
module tb_vliw_processor;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [7:0]  operand1;
    logic [7:0]  operand2;
    logic [7:0]  result1;
    logic [7:0]  result2;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] op1;
        logic [7:0] op2;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    vec_t vecs[$];

    vliw_processor dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .operand1    (operand1),
        .operand2    (operand2),
        .result1     (result1),
        .result2     (result2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0] op1, input logic [7:0] op2, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] e1, input logic [7:0] e2);
        vec_t v;
        v.op1 = op1; v.op2 = op2; v.a = a; v.b = b; v.e1 = e1; v.e2 = e2;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [7:0] op1, input logic [7:0] op2, input logic [7:0] a,
                         input logic [7:0] b);
        instruction = {op1, op2, 16'($urandom)};
        operand1    = a;
        operand2    = b;
    endtask

    initial begin
        // Sweep with A=0x3C, B=0x05; slot 2 runs the mirrored opcode.
        add_vec(8'h00, 8'h0C, 8'h3C, 8'h05, 8'h41, 8'h3B);
        add_vec(8'h01, 8'h0B, 8'h3C, 8'h05, 8'h37, 8'h3D);
        add_vec(8'h02, 8'h0A, 8'h3C, 8'h05, 8'h04, 8'h05);
        add_vec(8'h03, 8'h09, 8'h3C, 8'h05, 8'h3D, 8'h3C);
        add_vec(8'h04, 8'h08, 8'h3C, 8'h05, 8'h39, 8'h2C);
        add_vec(8'h05, 8'h07, 8'h3C, 8'h05, 8'hC3, 8'h01);
        add_vec(8'h06, 8'h06, 8'h3C, 8'h05, 8'h80, 8'h80);
        add_vec(8'h07, 8'h05, 8'h3C, 8'h05, 8'h01, 8'hC3);
        add_vec(8'h08, 8'h04, 8'h3C, 8'h05, 8'h2C, 8'h39);
        add_vec(8'h09, 8'h03, 8'h3C, 8'h05, 8'h3C, 8'h3D);
        add_vec(8'h0A, 8'h02, 8'h3C, 8'h05, 8'h05, 8'h04);
        add_vec(8'h0B, 8'h01, 8'h3C, 8'h05, 8'h3D, 8'h37);
        add_vec(8'h0C, 8'h00, 8'h3C, 8'h05, 8'h3B, 8'h41);
        add_vec(8'h0D, 8'hFF, 8'h3C, 8'h05, 8'h00, 8'h00);
        // Wrap and logic
        add_vec(8'h00, 8'h04, 8'hFF, 8'h01, 8'h00, 8'hFE);
        add_vec(8'h06, 8'h07, 8'hFF, 8'h0A, 8'hFC, 8'h3F);
        add_vec(8'h0C, 8'h0B, 8'h00, 8'h00, 8'hFF, 8'h01);
        // Illegal opcode in one slot only, same opcode in both slots
        add_vec(8'h0D, 8'h00, 8'h03, 8'h04, 8'h00, 8'h07);
        add_vec(8'h01, 8'h80, 8'h03, 8'h04, 8'hFF, 8'h00);
        add_vec(8'h08, 8'h08, 8'h10, 8'h11, 8'h10, 8'h10);
        // Back-to-back ADD/SUB, AND/OR, MUL/PASSB
        add_vec(8'h00, 8'h01, 8'h5A, 8'h33, 8'h8D, 8'h27);
        add_vec(8'h02, 8'h03, 8'h5A, 8'h33, 8'h12, 8'h7B);
        add_vec(8'h08, 8'h0A, 8'h5A, 8'h33, 8'hEE, 8'h33);

        // Reset asserted from time zero clears outputs before any edge.
        rst = 1'b1;
        instruction = 32'h0001_0000;
        operand1 = 8'h11;
        operand2 = 8'h22;
        #2;
        check("reset_async_r1", result1, 8'h00);
        check("reset_async_r2", result2, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_r1", result1, 8'h00);
        check("reset_hold_r2", result2, 8'h00);

        // Baseline: still zero before the first edge, then 12 / 0xFE.
        @(negedge clk);
        rst = 1'b0;
        drive(8'h00, 8'h01, 8'h05, 8'h07);
        #1;
        check("baseline_pre_r1", result1, 8'h00);
        check("baseline_pre_r2", result2, 8'h00);
        @(posedge clk);
        #1;
        check("baseline_r1", result1, 8'h0C);
        check("baseline_r2", result2, 8'hFE);

        // Table, one row per cycle; before each edge the previous row must still show.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op1, vecs[i].op2, vecs[i].a, vecs[i].b);
            if (i == 6) instruction[15:0] = 16'hxxxx;
            #1;
            if (i > 0) begin
                check($sformatf("vec%0d_hold_r1", i), result1, vecs[i-1].e1);
                check($sformatf("vec%0d_hold_r2", i), result2, vecs[i-1].e2);
            end
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_r1", i), result1, vecs[i].e1);
            check($sformatf("vec%0d_r2", i), result2, vecs[i].e2);
        end

        // Reset mid-stream, asserted and released between edges.
        drive(8'h00, 8'h01, 8'h05, 8'h07);
        @(posedge clk);
        #1;
        check("mid_pre_r1", result1, 8'h0C);
        check("mid_pre_r2", result2, 8'hFE);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_r1", result1, 8'h00);
        check("mid_rst_r2", result2, 8'h00);
        @(posedge clk);
        #1;
        check("mid_hold_r1", result1, 8'h00);
        check("mid_hold_r2", result2, 8'h00);
        drive(8'h01, 8'h04, 8'h09, 8'h03);
        #2;
        rst = 1'b0;
        #1;
        check("mid_release_r1", result1, 8'h00);
        check("mid_release_r2", result2, 8'h00);
        @(posedge clk);
        #1;
        check("mid_first_r1", result1, 8'h06);
        check("mid_first_r2", result2, 8'h0A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
